// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

    // Width of the per-channel settle counter (settle time 0..15 cycles).
    localparam int CNT_W = 4;

    // Scan sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Load/decrement counter that times the settle phase of each channel.
// expire is high on the last settle cycle, i.e. the cycle in which the
// count reaches zero on the next edge.
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);

    logic [W-1:0] cnt_q;

    // Counter: a load wins over a decrement; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4x1 decoder/tristate mux: steps sel over all channels,
// waits a settle time per channel, samples mux_y once per channel and hands
// the packed frame off on a valid/ready interface.
//
// Handshake: data_valid/data are a registered output stage. A word moves to
// the consumer on any edge where data_valid && data_ready. While data_valid
// is high and data_ready low, data holds steady. A new frame may enter the
// output stage in the same cycle the old one is accepted.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = $clog2(NUM_CH),
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              mux_y,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy
);

    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYC);
    // With no settle time a channel goes straight to its sample cycle.
    localparam state_t FIRST_ST = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [SEL_W-1:0]   ch_q;
    logic [NUM_CH-1:0]  shadow_q;
    logic [NUM_CH-1:0]  data_q;
    logic               valid_q;

    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_expire;
    logic               ch_inc;
    logic               ch_clr;
    logic               smp_en;
    logic               xfer_en;

    logic               go;
    logic               last_ch;
    logic               xfer_ok;

    assign go      = start || continuous;
    assign last_ch = (ch_q == LAST_CH);
    // Output stage can take a new frame if empty or being drained this cycle.
    assign xfer_ok = !valid_q || data_ready;

    settle_timer #(
        .W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_VAL),
        .dec      (tmr_dec),
        .expire   (tmr_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = FIRST_ST;
            SETTLE:  if (tmr_expire) state_d = SAMPLE;
            SAMPLE:  state_d = last_ch ? OUTPUT : FIRST_ST;
            OUTPUT:  if (xfer_ok) state_d = continuous ? FIRST_ST : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control strobes for timer, channel counter, shadow and output stage.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        ch_inc   = 1'b0;
        ch_clr   = 1'b0;
        smp_en   = 1'b0;
        xfer_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    tmr_load = 1'b1;
                    ch_clr   = 1'b1;
                end
            end
            SETTLE: begin
                tmr_dec = 1'b1;
            end
            SAMPLE: begin
                smp_en = 1'b1;
                if (!last_ch) begin
                    ch_inc   = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            OUTPUT: begin
                // Stalled: channel and shadow stay frozen until a transfer.
                if (xfer_ok) begin
                    xfer_en  = 1'b1;
                    ch_clr   = 1'b1;
                    tmr_load = continuous;
                end
            end
            default: begin
                ch_clr = 1'b1;
            end
        endcase
    end

    // Channel counter; only ever reloaded to zero, never wraps on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= '0;
        end else if (ch_clr) begin
            ch_q <= '0;
        end else if (ch_inc) begin
            ch_q <= ch_q + SEL_W'(1);
        end
    end

    // Shadow register collects one mux_y sample per channel, unfiltered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (smp_en) begin
            shadow_q[ch_q] <= mux_y;
        end
    end

    // Output stage: load on transfer, otherwise drop valid once accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (xfer_en) begin
            data_q  <= shadow_q;
            valid_q <= 1'b1;
        end else if (data_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign sel        = ch_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: default instance plus a zero-settle instance,
// each fed by a behavioural 4x1 mux indexed by the DUT's sel.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    // Default instance (SETTLE_CYC = 2)
    logic       start;
    logic       continuous;
    logic       data_ready;
    logic [3:0] bus;
    logic       mux_y;
    logic [1:0] sel;
    logic [3:0] data;
    logic       data_valid;
    logic       busy;

    // Zero-settle instance
    logic       start0;
    logic       continuous0;
    logic       ready0;
    logic [3:0] bus0;
    logic       mux_y0;
    logic [1:0] sel0;
    logic [3:0] data0;
    logic       valid0;
    logic       busy0;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp0_q[$];

    assign mux_y  = bus[sel];
    assign mux_y0 = bus0[sel0];

    mux_scan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .mux_y      (mux_y),
        .sel        (sel),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy)
    );

    mux_scan_ctrl #(.SETTLE_CYC(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start0),
        .continuous (continuous0),
        .mux_y      (mux_y0),
        .sel        (sel0),
        .data       (data0),
        .data_valid (valid0),
        .data_ready (ready0),
        .busy       (busy0)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the default instance: every accepted word pops the queue.
    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_frame: got data %0h with no frame expected", data);
            end else begin
                check("frame_data", 32'(data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Monitor for the zero-settle instance.
    always @(negedge clk) begin
        if (rst_n && valid0 && ready0) begin
            if (exp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_frame0: got data %0h with no frame expected", data0);
            end else begin
                check("frame_data0", 32'(data0), 32'(exp0_q.pop_front()));
            end
        end
    end

    // Pulse start for one edge and count edges until data_valid rises.
    task automatic frame_latency(output int lat);
        lat = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (data_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    // Wait (bounded) for the default instance to be idle with no word pending.
    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy && !data_valid) break;
            @(posedge clk); #1;
        end
        check("wait_idle", 32'({busy, data_valid}), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        rst_n       = 1'b0;
        start       = 1'b0;
        continuous  = 1'b0;
        data_ready  = 1'b1;
        bus         = 4'b0000;
        start0      = 1'b0;
        continuous0 = 1'b0;
        ready0      = 1'b1;
        bus0        = 4'b0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        rst_n = 1'b1;

        // 1: bus 1010, sel stepping, latency 13, busy drops
        bus = 4'b1010;
        exp_q.push_back(4'b1010);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k <= 11) check("t1_sel", 32'(sel), 32'(k / 3));
            if (k == 12) begin
                check("t1_sel_out", 32'(sel), 32'd3);
                check("t1_valid_early", 32'(data_valid), 32'd0);
                check("t1_busy", 32'(busy), 32'd1);
            end
            if (k == 13) begin
                check("t1_valid", 32'(data_valid), 32'd1);
                check("t1_data", 32'(data), 32'hA);
                check("t1_busy_after", 32'(busy), 32'd0);
                check("t1_sel_after", 32'(sel), 32'd0);
            end
        end
        @(posedge clk); #1;
        check("t1_valid_drop", 32'(data_valid), 32'd0);

        // 2: all 16 bus values, one-shot frames
        for (int v = 0; v < 16; v++) begin
            bus = 4'(v);
            exp_q.push_back(4'(v));
            frame_latency(lat);
            check("t2_latency", 32'(lat), 32'd13);
            wait_idle();
        end

        // 3: back-pressure with continuous scanning
        data_ready = 1'b0;
        bus        = 4'b0110;
        exp_q.push_back(4'b0110);
        @(posedge clk); #1 continuous = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (data_valid) break;
        end
        check("t3_valid1", 32'(data_valid), 32'd1);
        check("t3_data1", 32'(data), 32'h6);
        bus = 4'b1001;
        exp_q.push_back(4'b1001);
        repeat (20) @(posedge clk);
        #1;
        check("t3_stall_sel", 32'(sel), 32'd3);
        check("t3_stall_busy", 32'(busy), 32'd1);
        check("t3_stall_data", 32'(data), 32'h6);
        check("t3_stall_valid", 32'(data_valid), 32'd1);
        continuous = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t3_hold_data", 32'(data), 32'h6);
        data_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_data2", 32'(data), 32'h9);
        check("t3_valid2", 32'(data_valid), 32'd1);
        check("t3_busy2", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("t3_valid_drop", 32'(data_valid), 32'd0);

        // 4: async reset mid-frame, then a clean full frame
        bus = 4'b0011;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sel == 2'd2) break;
            @(posedge clk); #1;
        end
        check("t4_pre_sel", 32'(sel), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_sel", 32'(sel), 32'd0);
        check("t4_rst_valid", 32'(data_valid), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_data", 32'(data), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        bus = 4'b0101;
        exp_q.push_back(4'b0101);
        frame_latency(lat);
        check("t4_latency", 32'(lat), 32'd13);
        wait_idle();

        // 5: start re-pulsed while busy is ignored
        bus = 4'b1110;
        exp_q.push_back(4'b1110);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_valid", 32'(data_valid), 32'd0);
        check("t5_pending", 32'(exp_q.size()), 32'd0);

        // 6: zero settle time, bus 1100
        bus0 = 4'b1100;
        exp0_q.push_back(4'b1100);
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k <= 3) check("t6_sel", 32'(sel0), 32'(k));
            if (k == 4) check("t6_valid_early", 32'(valid0), 32'd0);
            if (k == 5) begin
                check("t6_valid", 32'(valid0), 32'd1);
                check("t6_data", 32'(data0), 32'hC);
                check("t6_busy", 32'(busy0), 32'd0);
            end
        end
        repeat (5) @(posedge clk);
        #1;

        check("final_queue", 32'(exp_q.size()), 32'd0);
        check("final_queue0", 32'(exp0_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
